// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcodes and
// datapath select codes (aluop is also consumed by alu_decoder).
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_RDATA     = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic is_mem;
        logic is_rtype;
        logic is_itype;
        logic is_jal;
        logic is_beq;
    } op_class_t;

endpackage

// File: rtl/instr_decoder.sv
// Opcode classifier: immediate format select plus the one-hot instruction class
// that steers the decode state.
module instr_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] i_op,
    output logic [1:0] o_immsrc,
    output op_class_t  o_class
);

    always_comb begin
        o_immsrc = IMM_I;
        o_class  = '0;
        case (i_op)
            OP_LOAD: begin
                o_immsrc       = IMM_I;
                o_class.is_mem = 1'b1;
            end
            OP_STORE: begin
                o_immsrc       = IMM_S;
                o_class.is_mem = 1'b1;
            end
            OP_RTYPE: o_class.is_rtype = 1'b1;
            OP_ITYPE: begin
                o_immsrc         = IMM_I;
                o_class.is_itype = 1'b1;
            end
            OP_JAL: begin
                o_immsrc       = IMM_J;
                o_class.is_jal = 1'b1;
            end
            OP_BEQ: begin
                o_immsrc       = IMM_B;
                o_class.is_beq = 1'b1;
            end
            default: o_class = '0;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and
// drives datapath selects, write enables and aluop, stalling on mem_ready.
module main_fsm
    import ctrl_pkg::*;
#(
    parameter int STATE_W         = 4,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         i_op,
    input  logic               i_zero,
    input  logic               i_mem_ready,
    output logic               o_pcwrite,
    output logic               o_adrsrc,
    output logic               o_irwrite,
    output logic               o_memwrite,
    output logic               o_regwrite,
    output logic [1:0]         o_alusrca,
    output logic [1:0]         o_alusrcb,
    output logic [1:0]         o_resultsrc,
    output logic [1:0]         o_aluop,
    output logic [1:0]         o_immsrc,
    output logic               o_illegal,
    output logic [STATE_W-1:0] o_state_dbg
);

    state_t    r_state;
    state_t    w_next_state;
    op_class_t w_class;
    logic      w_pcupdate;
    logic      w_branch;
    logic      w_irwrite;
    logic      w_memwrite;
    logic      w_regwrite;

    instr_decoder u_instr_decoder (
        .i_op     (i_op),
        .o_immsrc (o_immsrc),
        .o_class  (w_class)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    if (i_mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                if      (w_class.is_mem)   w_next_state = S_MEMADR;
                else if (w_class.is_rtype) w_next_state = S_EXECR;
                else if (w_class.is_itype) w_next_state = S_EXECI;
                else if (w_class.is_jal)   w_next_state = S_JAL;
                else if (w_class.is_beq)   w_next_state = S_BEQ;
                else                       w_next_state = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
            end
            S_MEMADR:   w_next_state = i_op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (i_mem_ready) w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: if (i_mem_ready) w_next_state = S_FETCH;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            S_BEQ:      w_next_state = S_FETCH;
            S_TRAP:     w_next_state = S_TRAP;
            default:    w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_pcupdate  = 1'b0;
        w_branch    = 1'b0;
        w_irwrite   = 1'b0;
        w_memwrite  = 1'b0;
        w_regwrite  = 1'b0;
        o_adrsrc    = 1'b0;
        o_alusrca   = SRCA_PC;
        o_alusrcb   = SRCB_RS2;
        o_resultsrc = RES_ALUOUT;
        o_aluop     = ALUOP_ADD;
        o_illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_alusrcb   = SRCB_FOUR;
                o_resultsrc = RES_ALURESULT;
                w_irwrite   = i_mem_ready;
                w_pcupdate  = i_mem_ready;
            end
            S_DECODE: begin
                o_alusrca = SRCA_OLDPC;
                o_alusrcb = SRCB_IMM;
            end
            S_MEMADR: begin
                o_alusrca = SRCA_RS1;
                o_alusrcb = SRCB_IMM;
            end
            S_MEMREAD:  o_adrsrc = 1'b1;
            S_MEMWB: begin
                o_resultsrc = RES_RDATA;
                w_regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                o_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECR: begin
                o_alusrca = SRCA_RS1;
                o_alusrcb = SRCB_RS2;
                o_aluop   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                o_alusrca = SRCA_RS1;
                o_alusrcb = SRCB_IMM;
                o_aluop   = ALUOP_FUNCT;
            end
            S_ALUWB:    w_regwrite = 1'b1;
            S_JAL: begin
                o_alusrca  = SRCA_OLDPC;
                o_alusrcb  = SRCB_FOUR;
                w_pcupdate = 1'b1;
            end
            S_BEQ: begin
                o_alusrca = SRCA_RS1;
                o_alusrcb = SRCB_RS2;
                o_aluop   = ALUOP_SUB;
                w_branch  = 1'b1;
            end
            S_TRAP:     o_illegal = 1'b1;
            default:    o_illegal = 1'b0;
        endcase
    end

    // Enables are gated by rst_n so nothing is written while reset is held,
    // including the fetch strobes that follow mem_ready combinationally.
    assign o_pcwrite   = rst_n & (w_pcupdate | (w_branch & i_zero));
    assign o_irwrite   = rst_n & w_irwrite;
    assign o_memwrite  = rst_n & w_memwrite;
    assign o_regwrite  = rst_n & w_regwrite;
    assign o_state_dbg = STATE_W'(r_state);

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: two instances (trap on / trap off) share stimulus;
// each scenario pushes expected outputs as it drives and pops them at the negedge.
module tb_main_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       irw;
        logic       memw;
        logic       regw;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] res;
        logic [1:0] aop;
        logic [1:0] imm;
        logic       ill;
    } outs_t;

    // enable field order: pcwrite adrsrc irwrite memwrite regwrite
    localparam outs_t E_FETCH    = {4'd0,  5'b10100, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam outs_t E_FETCHW   = {4'd0,  5'b00000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam outs_t E_DECODE   = {4'd1,  5'b00000, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam outs_t E_MEMADR   = {4'd2,  5'b00000, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam outs_t E_MEMREAD  = {4'd3,  5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam outs_t E_MEMWB    = {4'd4,  5'b00001, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam outs_t E_MEMWRITE = {4'd5,  5'b01010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam outs_t E_EXECR    = {4'd6,  5'b00000, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam outs_t E_EXECI    = {4'd7,  5'b00000, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam outs_t E_ALUWB    = {4'd8,  5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam outs_t E_JAL      = {4'd9,  5'b10000, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam outs_t E_BEQT     = {4'd10, 5'b10000, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam outs_t E_BEQN     = {4'd10, 5'b00000, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam outs_t E_TRAP     = {4'd11, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       memReady;

    logic       pcwrite, adrsrc, irwrite, memwrite, regwrite, illegal;
    logic [1:0] alusrca, alusrcb, resultsrc, aluop, immsrc;
    logic [3:0] stDbg;
    logic       pcwrite0, adrsrc0, irwrite0, memwrite0, regwrite0, illegal0;
    logic [1:0] alusrca0, alusrcb0, resultsrc0, aluop0, immsrc0;
    logic [3:0] stDbg0;

    outs_t obs;
    outs_t obs0;
    outs_t expQ[$];
    int    total;
    int    bad;

    main_fsm #(.STATE_W(4), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_op        (op),
        .i_zero      (zero),
        .i_mem_ready (memReady),
        .o_pcwrite   (pcwrite),
        .o_adrsrc    (adrsrc),
        .o_irwrite   (irwrite),
        .o_memwrite  (memwrite),
        .o_regwrite  (regwrite),
        .o_alusrca   (alusrca),
        .o_alusrcb   (alusrcb),
        .o_resultsrc (resultsrc),
        .o_aluop     (aluop),
        .o_immsrc    (immsrc),
        .o_illegal   (illegal),
        .o_state_dbg (stDbg)
    );

    main_fsm #(.STATE_W(4), .TRAP_ON_ILLEGAL(1'b0)) dutNoTrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_op        (op),
        .i_zero      (zero),
        .i_mem_ready (memReady),
        .o_pcwrite   (pcwrite0),
        .o_adrsrc    (adrsrc0),
        .o_irwrite   (irwrite0),
        .o_memwrite  (memwrite0),
        .o_regwrite  (regwrite0),
        .o_alusrca   (alusrca0),
        .o_alusrcb   (alusrcb0),
        .o_resultsrc (resultsrc0),
        .o_aluop     (aluop0),
        .o_immsrc    (immsrc0),
        .o_illegal   (illegal0),
        .o_state_dbg (stDbg0)
    );

    assign obs  = {stDbg, pcwrite, adrsrc, irwrite, memwrite, regwrite,
                   alusrca, alusrcb, resultsrc, aluop, immsrc, illegal};
    assign obs0 = {stDbg0, pcwrite0, adrsrc0, irwrite0, memwrite0, regwrite0,
                   alusrca0, alusrcb0, resultsrc0, aluop0, immsrc0, illegal0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        outs_t e;
        outs_t got;
        rst_n    = 1'b0;
        op       = 7'b0000000;
        zero     = 1'b0;
        memReady = 1'b1;
        repeat (2) @(negedge clk);
        e = E_FETCHW;
        expQ.push_back(e);
        #1 got = obs;
        e = expQ.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("[TB] FAIL reset_hold: got=%h want=%h", got, e);
        end
        @(negedge clk);
        memReady = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_rtype();
        outs_t seq[5] = '{E_FETCHW, E_FETCH, E_DECODE, E_EXECR, E_ALUWB};
        logic  mr[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        outs_t e;
        outs_t got;
        op = 7'b0110011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            memReady = mr[i];
            e = seq[i];
            e.imm = 2'b00;
            expQ.push_back(e);
            #1 got = obs;
            e = expQ.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("[TB] FAIL rtype[%0d]: got=%h want=%h", i, got, e);
            end
        end
    endtask

    task automatic test_itype();
        outs_t seq[4] = '{E_FETCH, E_DECODE, E_EXECI, E_ALUWB};
        outs_t e;
        outs_t got;
        op = 7'b0010011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            memReady = 1'b1;
            e = seq[i];
            e.imm = 2'b00;
            expQ.push_back(e);
            #1 got = obs;
            e = expQ.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("[TB] FAIL itype[%0d]: got=%h want=%h", i, got, e);
            end
        end
    endtask

    task automatic test_store();
        outs_t seq[5] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWRITE, E_MEMWRITE};
        logic  mr[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        outs_t e;
        outs_t got;
        op = 7'b0100011;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            memReady = mr[i];
            e = seq[i];
            e.imm = 2'b01;
            expQ.push_back(e);
            #1 got = obs;
            e = expQ.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("[TB] FAIL store[%0d]: got=%h want=%h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        outs_t seq[4] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWRITE};
        logic  mr[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        outs_t e;
        outs_t got;
        op = 7'b0100011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            memReady = mr[i];
            e = seq[i];
            e.imm = 2'b01;
            expQ.push_back(e);
            #1 got = obs;
            e = expQ.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("[TB] FAIL midstore[%0d]: got=%h want=%h", i, got, e);
            end
        end
        #1 rst_n = 1'b0;
        e = E_FETCHW;
        e.imm = 2'b01;
        expQ.push_back(e);
        #1 got = obs;
        e = expQ.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("[TB] FAIL midstore_async_reset: got=%h want=%h", got, e);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst_n    = 1'b1;
            memReady = 1'b0;
            e = E_FETCHW;
            e.imm = 2'b01;
            expQ.push_back(e);
            #1 got = obs;
            e = expQ.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("[TB] FAIL midstore_release[%0d]: got=%h want=%h", i, got, e);
            end
        end
    endtask

    task automatic test_load_wait();
        outs_t seq[8] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD,
                          E_MEMREAD, E_MEMREAD, E_MEMREAD, E_MEMWB};
        logic  mr[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        outs_t e;
        outs_t got;
        op = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            memReady = mr[i];
            e = seq[i];
            e.imm = 2'b00;
            expQ.push_back(e);
            #1 got = obs;
            e = expQ.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("[TB] FAIL load[%0d]: got=%h want=%h", i, got, e);
            end
        end
    endtask

    task automatic test_beq();
        outs_t seq[6] = '{E_FETCH, E_DECODE, E_BEQT, E_FETCH, E_DECODE, E_BEQN};
        logic  zz[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        outs_t e;
        outs_t got;
        op = 7'b1100011;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            memReady = 1'b1;
            zero     = zz[i];
            e = seq[i];
            e.imm = 2'b10;
            expQ.push_back(e);
            #1 got = obs;
            e = expQ.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("[TB] FAIL beq[%0d]: got=%h want=%h", i, got, e);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        outs_t seq[4] = '{E_FETCH, E_DECODE, E_JAL, E_ALUWB};
        outs_t e;
        outs_t got;
        op = 7'b1101111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            memReady = 1'b1;
            e = seq[i];
            e.imm = 2'b11;
            expQ.push_back(e);
            #1 got = obs;
            e = expQ.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("[TB] FAIL jal[%0d]: got=%h want=%h", i, got, e);
            end
        end
    endtask

    task automatic test_illegal();
        outs_t seqT[5] = '{E_FETCH, E_DECODE, E_TRAP, E_TRAP, E_TRAP};
        outs_t seqN[5] = '{E_FETCH, E_DECODE, E_FETCHW, E_FETCHW, E_FETCHW};
        logic  mr[5]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        outs_t e;
        outs_t got;
        op = 7'b1111111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            memReady = mr[i];
            expQ.push_back(seqT[i]);
            expQ.push_back(seqN[i]);
            #1 got = obs;
            e = expQ.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("[TB] FAIL illegal_trap[%0d]: got=%h want=%h", i, got, e);
            end
            got = obs0;
            e = expQ.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("[TB] FAIL illegal_notrap[%0d]: got=%h want=%h", i, got, e);
            end
        end
        rst_n = 1'b0;
        expQ.push_back(E_FETCHW);
        #1 got = obs;
        e = expQ.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("[TB] FAIL illegal_reset_clears: got=%h want=%h", got, e);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        op       = 7'b0000000;
        zero     = 1'b0;
        memReady = 1'b0;
        test_reset();
        test_rtype();
        test_itype();
        test_store();
        test_reset_mid_store();
        test_load_wait();
        test_beq();
        test_jal();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
